// File: rtl/dot_matrix_pkg.sv
// Shared types and helpers for the dot-matrix display path.
// Used by both the pattern generator and the row scan driver.
package dot_matrix_pkg;

    localparam int ROWS_DEF = 4;
    localparam int COLS_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } scan_state_e;

    function automatic int pix_idx(input int r, input int c);
        return r * COLS_DEF + c;
    endfunction

endpackage

// File: rtl/dot_matrix_slot_timer.sv
// Row slot timer: cycle counter within a slot plus the current row.
// Counters sit at zero whenever run is low.
module dot_matrix_slot_timer #(
    parameter int ROWS  = 4,
    parameter int DIV   = 1000,
    parameter int BLANK = 8,
    localparam int RW   = $clog2(ROWS),
    localparam int CW   = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          blank,
    output logic          slot_end,
    output logic          frame_end,
    output logic [RW-1:0] row_idx
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;

    assign blank     = int'(cnt_q) < BLANK;
    assign slot_end  = cnt_q == CW'(DIV - 1);
    assign frame_end = slot_end && (row_q == RW'(ROWS - 1));
    assign row_idx   = row_q;

    always_comb begin
        cnt_d = cnt_q;
        row_d = row_q;
        if (!run) begin
            cnt_d = '0;
            row_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/dot_matrix_scan.sv
// Row-multiplexed LED scan driver with a double-buffered frame
// and per-slot blanking; frames swap only at frame boundaries.
module dot_matrix_scan
    import dot_matrix_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int DIV   = 1000,
    parameter int BLANK = 8,
    localparam int N    = ROWS * COLS,
    localparam int RW   = $clog2(ROWS),
    localparam int IW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    frame_in,
    input  logic            frame_valid,
    output logic            frame_ready,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_data,
    output logic [RW-1:0]   row_idx,
    output logic            frame_start
);

    logic        active_q, active_d;
    logic        pend_full_q, pend_full_d;
    logic        frame_start_q, frame_start_d;
    logic [N-1:0] disp_q, disp_d;
    logic [N-1:0] pend_q, pend_d;

    logic        blank, slot_end, frame_end;
    logic        acc, swap;
    logic [IW-1:0] idx;
    scan_state_e state;

    dot_matrix_slot_timer #(
        .ROWS (ROWS),
        .DIV  (DIV),
        .BLANK(BLANK)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (en && active_q),
        .blank    (blank),
        .slot_end (slot_end),
        .frame_end(frame_end),
        .row_idx  (row_idx)
    );

    assign state = !active_q ? S_IDLE :
                   blank     ? S_BLANK : S_DRIVE;

    assign frame_ready = !pend_full_q;
    assign frame_start = frame_start_q;

    // Swapping while idle lets a frame loaded before enable show at once.
    assign acc  = frame_valid && !pend_full_q;
    assign swap = pend_full_q && (!active_q || frame_end);

    always_comb begin
        row_sel  = '0;
        col_data = '0;
        idx      = '0;
        if (state == S_DRIVE) begin
            row_sel[row_idx] = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                idx         = IW'(pix_idx(int'(row_idx), c));
                col_data[c] = disp_q[idx];
            end
        end
    end

    always_comb begin
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (swap) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end else if (acc) begin
            pend_d      = frame_in;
            pend_full_d = 1'b1;
        end
        active_d      = en;
        frame_start_d = en && (!active_q ||
                        (slot_end && row_idx == RW'(ROWS - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q      <= 1'b0;
            pend_full_q   <= 1'b0;
            frame_start_q <= 1'b0;
            disp_q        <= '0;
            pend_q        <= '0;
        end else begin
            active_q      <= active_d;
            pend_full_q   <= pend_full_d;
            frame_start_q <= frame_start_d;
            disp_q        <= disp_d;
            pend_q        <= pend_d;
        end
    end

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Bench for dot_matrix_scan: directed scenarios then random traffic,
// checked every cycle against a frame-period arithmetic model.
module tb_dot_matrix_scan;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DIV  = 10;
    localparam int BLK  = 2;
    localparam int PER  = DIV * ROWS;

    logic        clk = 0;
    logic        rst, en, frame_valid;
    logic [15:0] frame_in;
    logic        frame_ready, frame_start;
    logic [3:0]  row_sel, col_data;
    logic [1:0]  row_idx;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit          m_act;
    int          m_t;
    logic [15:0] m_disp, m_pend;
    bit          m_full;
    bit          m_acc;

    dot_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .row_idx    (row_idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int cnt, row;
        logic [15:0] sh;
        logic [3:0] e_sel, e_col;
        logic [1:0] e_row;
        logic e_fs;
        e_sel = 0; e_col = 0; e_row = 0; e_fs = 0;
        if (m_act) begin
            cnt   = m_t % DIV;
            row   = (m_t / DIV) % ROWS;
            e_row = 2'(row);
            e_fs  = (m_t % PER) == 0;
            if (cnt >= BLK) begin
                e_sel = 4'(1 << row);
                sh    = m_disp >> (row * COLS);
                e_col = sh[3:0];
            end
        end
        chk("row_sel", 32'(row_sel), 32'(e_sel));
        chk("col_data", 32'(col_data), 32'(e_col));
        chk("row_idx", 32'(row_idx), 32'(e_row));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("frame_ready", 32'(frame_ready), 32'(!m_full));
    endtask

    task automatic model_edge();
        bit boundary;
        m_acc = 0;
        if (rst) begin
            m_act = 0; m_t = 0; m_disp = 0; m_pend = 0; m_full = 0;
            return;
        end
        boundary = !m_act || ((m_t % PER) == PER - 1);
        if (m_full && boundary) begin
            m_disp = m_pend;
            m_full = 0;
        end else if (frame_valid && !m_full) begin
            m_pend = frame_in;
            m_full = 1;
            m_acc  = 1;
        end
        if (!en) begin
            m_act = 0; m_t = 0;
        end else if (!m_act) begin
            m_act = 1; m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_pos(input int pos);
        int n = 0;
        while (!(m_act && (m_t % PER) == pos) && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $error("FAIL wait_pos timeout pos=%0d", pos);
        end
    endtask

    task automatic offer(input logic [15:0] f);
        int n = 0;
        frame_valid = 1;
        frame_in    = f;
        do begin
            cycle();
            n++;
        end while (!m_acc && n < 200);
        frame_valid = 0;
        if (!m_acc) begin
            tests++; fails++;
            $error("FAIL offer timeout frame=%0h", f);
        end
    endtask

    initial begin
        rst = 1; en = 1; frame_valid = 1; frame_in = 16'hFFFF;
        m_act = 0; m_t = 0; m_disp = 0; m_pend = 0;
        m_full = 0; m_acc = 0;
        @(posedge clk);
        #1;
        run(3);

        // idle load then enable
        rst = 0; en = 0; frame_valid = 0;
        run(2);
        offer(16'h8421);
        run(3);
        en = 1;
        run(45);

        // mid-frame load during row 1
        wait_pos(12);
        offer(16'hFFFF);
        run(90);

        // back-pressure: second frame held until boundary
        wait_pos(3);
        offer(16'h0001);
        offer(16'h0003);
        run(90);

        // enable drop at row 2, cnt 5
        wait_pos(25);
        en = 0;
        run(3);
        en = 1;
        run(45);

        // accept exactly on the boundary cycle
        wait_pos(39);
        frame_valid = 1;
        frame_in    = 16'h5A3C;
        cycle();
        frame_valid = 0;
        run(90);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) en = ~en;
            frame_valid = ($urandom_range(0, 7) == 0);
            frame_in    = 16'($urandom);
            cycle();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dot_matrix_scan.md
Name: dot_matrix_scan

Overview:
Row-multiplexing scan driver that sits directly downstream of the 4x4 dot-matrix pattern generator. It accepts a full frame image over a valid/ready handshake and double-buffers it. It then time-multiplexes the frame onto physical LED row-select and column-data lines, with a blanking gap at the start of every row slot to suppress ghosting. Frames swap only at frame boundaries, so the display never tears.

Parameters:
ROWS, 4, number of matrix rows (row_sel width)
COLS, 4, number of matrix columns (col_data width)
DIV, 1000, clk cycles per row slot; legal range DIV >= 2
BLANK, 8, blanked cycles at the start of each slot; legal range 0 <= BLANK < DIV

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  power/enable; 0 = scan stopped and outputs dark
frame_in  in  ROWS*COLS  frame image; bit r*COLS+c is pixel (row r, col c), 1 = lit
frame_valid  in  1  frame_in is offered
frame_ready  out  1  pending buffer is empty; transfer occurs when valid && ready
row_sel  out  ROWS  one-hot row drive, active-high
col_data  out  COLS  column data for the driven row; col_data[c] = pixel (row_idx, c)
row_idx  out  $clog2(ROWS)  row currently in its slot
frame_start  out  1  one-cycle pulse on the first cycle of the row-0 slot

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Internal state:
  - slot counter cnt, range 0..DIV-1
  - row_idx
  - display buffer disp and pending buffer pend, each ROWS*COLS bits
  - pend_full flag
  - state register: IDLE, BLANK, DRIVE
- Reset: all of the above go to 0 and state goes to IDLE. Outputs are row_sel=0, col_data=0, row_idx=0, frame_start=0, frame_ready=1. A reset mid-scan takes effect on the next edge; the frame in progress is discarded.
- Handshake:
  - frame_ready = !pend_full (combinational from the register).
  - On valid && ready: pend <= frame_in and pend_full <= 1.
  - frame_valid while not ready is held off; the upstream keeps frame_in stable.
- IDLE (en=0):
  - row_sel=0, col_data=0, cnt and row_idx held at 0.
  - If pend_full, then disp <= pend and pend_full <= 0 on the next edge. Latency from accept to disp is 2 edges.
  - When en=1, the next edge enters BLANK with cnt=0 and row_idx=0, and frame_start=1 on that cycle.
- Scanning:
  - cnt increments every cycle.
  - cnt < BLANK: state BLANK, row_sel=0, col_data=0.
  - cnt >= BLANK: state DRIVE, row_sel = one-hot(row_idx), col_data = disp row slice.
  - If BLANK=0, BLANK is never entered.
- Slot end (cnt==DIV-1):
  - cnt wraps to 0 and row_idx increments.
  - row_idx==ROWS-1 wraps to 0. This is the frame boundary: if pend_full, then disp <= pend and pend_full <= 0 on the same edge.
  - frame_start=1 whenever cnt==0 && row_idx==0 && state != IDLE.
- Simultaneous accept and boundary: an accept on the boundary cycle can only happen with pend_full=0, so no swap occurs. The new frame is displayed at the following boundary, one frame later.
- en deasserted mid-slot: the next edge goes to IDLE and outputs are dark. Scan position is lost; re-enable always restarts at row 0.
- Outputs are registered: row_sel, col_data, row_idx and frame_start are consistent with the cnt/row_idx/state registers in the same cycle, with no combinational path from inputs. frame_ready is the only decoded output.

Decomposition:
- Package dot_matrix_pkg holds:
  - default ROWS/COLS constants;
  - the scan state enum (IDLE, BLANK, DRIVE);
  - a function pix_idx(r,c) = r*COLS+c, shared with the pattern generator.
- Sub-module dot_matrix_slot_timer holds the cnt/row_idx counters. Its outputs are blank, slot_end, frame_end and row_idx, and its inputs are clk, rst and run.

Test Plan:
- Reset: rst=1 for 3 cycles with en=1 and frame_valid=1 -> row_sel=0, col_data=0, frame_start=0, frame_ready=1, and no frame accepted.
- Idle load (DIV=10, BLANK=2): en=0, offer 16'h8421 -> ready drops for 1 cycle. Then en=1 -> frame_start pulse. Row 0 gives 2 dark cycles, then 8 cycles of row_sel=0001, col_data=0001. Rows 1-3 show col_data 0010, 0100, 1000. Period is 40 cycles.
- Mid-frame load: while scanning 16'h8421, offer 16'hFFFF during row 1 -> accepted and ready=0 until the boundary. Rows 2-3 still show 0100/1000. The next frame shows 1111 on every row, and ready=1 on the cycle after the swap.
- Back-pressure: offer 16'h0001, then 16'h0003 during the same frame -> the second stays unaccepted (ready=0) until the boundary. 16'h0001 is displayed for exactly one frame, then 16'h0003 from the next.
- Enable drop: deassert en at row 2, cnt=5 -> next cycle row_sel=0, col_data=0. Re-assert -> frame_start and row 0 blanking restart at cnt=0.
- Boundary edge case: offer a frame exactly on the row-3 cnt==9 cycle with pend empty -> accepted, with no swap that edge. It appears one frame later.
